// File: rtl/clint_timer_pkg.sv
// CLINT register map, CSR bit positions, bus FSM states and the
// byte-lane merge used for partial writes of 64-bit registers.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    localparam int MCOUNTINHIBIT_TM_BIT = 1;
    localparam int MENVCFG_STCE_BIT     = 63;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/csr_pkg.sv
// CSR-file types shared across the CSR/CLINT boundary: a raw 64-bit CSR
// value and the write strobe/data pair the CLINT uses to update `time`.
package csr_pkg;

    typedef union packed {
        logic [63:0] raw;
        struct packed {
            logic [31:0] hi;
            logic [31:0] lo;
        } half;
    } csr_reg_u;

    typedef struct packed {
        logic        we;
        logic [63:0] wdata;
    } csr_w_t;

endpackage

// File: rtl/csr_clint_if.sv
// Point-to-point link between the CSR file and the CLINT: the CSR file
// owns `time`, the CLINT advances it and reports timer interrupt levels.
interface csr_clint_if;
    import csr_pkg::*;

    csr_reg_u time_rdata;
    csr_reg_u mcountinhibit_rdata;
    csr_reg_u stimecmp_rdata;
    csr_reg_u menvcfg_rdata;
    csr_w_t   time_w;
    logic     mip_stip;
    logic     mip_mtip;

    modport clint (
        input  time_rdata, mcountinhibit_rdata, stimecmp_rdata, menvcfg_rdata,
        output time_w, mip_stip, mip_mtip
    );

    modport csr (
        output time_rdata, mcountinhibit_rdata, stimecmp_rdata, menvcfg_rdata,
        input  time_w, mip_stip, mip_mtip
    );

endinterface

// File: rtl/clint_tick_gen.sv
// mtime prescaler: counts 0..TICK_DIV-1 while enabled and pulses `tick`
// on the wrap cycle; `clr` restarts the count and suppresses that tick.
module clint_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_timer.sv
// Single-hart CLINT: advances the CSR `time` register, compares it against
// mtimecmp/stimecmp, and serves msip/mtimecmp/mtime over a one-deep bus port.
module clint_timer
    import csr_pkg::*;
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    csr_clint_if.clint        csr_clint,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              msip
);

    bus_state_e        state_q, state_d;
    logic              msip_q, msip_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic              mip_mtip_q, mip_mtip_d;
    logic              mip_stip_q, mip_stip_d;
    csr_w_t            time_w_q, time_w_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept, mtime_wr, tick, tm_inhibit, stce;
    logic              sel_msip, sel_mtimecmp, sel_mtime;
    logic [ADDR_W-1:0] word_addr;
    logic [63:0]       time_now, time_base;
    logic              unused_bits;

    assign time_now   = csr_clint.time_rdata.raw;
    assign tm_inhibit = csr_clint.mcountinhibit_rdata.raw[MCOUNTINHIBIT_TM_BIT];
    assign stce       = csr_clint.menvcfg_rdata.raw[MENVCFG_STCE_BIT];
    assign unused_bits = ^{req_addr[2:0],
                           csr_clint.mcountinhibit_rdata.raw[63:2],
                           csr_clint.mcountinhibit_rdata.raw[0],
                           csr_clint.menvcfg_rdata.raw[62:0]};

    assign word_addr    = {req_addr[ADDR_W-1:3], 3'b000};
    assign sel_msip     = (word_addr == ADDR_W'(CLINT_MSIP_OFS));
    assign sel_mtimecmp = (word_addr == ADDR_W'(CLINT_MTIMECMP_OFS));
    assign sel_mtime    = (word_addr == ADDR_W'(CLINT_MTIME_OFS));

    clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (!tm_inhibit),
        .clr  (mtime_wr),
        .tick (tick)
    );

    // Bus FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (req_valid) state_d = BUS_RESP;
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // Bus FSM: outputs
    always_comb begin
        req_ready  = (state_q == BUS_IDLE);
        resp_valid = (state_q == BUS_RESP);
    end

    assign accept = req_valid && req_ready;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        msip_d       = msip_q;
        mtimecmp_d   = mtimecmp_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mtime_wr     = 1'b0;
        if (accept) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            if (sel_msip) begin
                if (req_we) begin
                    if (req_wstrb[0]) msip_d = req_wdata[0];
                end else begin
                    resp_rdata_d = {63'd0, msip_q};
                end
            end else if (sel_mtimecmp) begin
                if (req_we) mtimecmp_d   = byte_merge(mtimecmp_q, req_wdata, req_wstrb);
                else        resp_rdata_d = mtimecmp_q;
            end else if (sel_mtime) begin
                if (req_we) mtime_wr     = 1'b1;
                else        resp_rdata_d = time_now;
            end else begin
                resp_err_d = 1'b1;
            end
        end
    end

    // time_rdata lags an issued write by two cycles, so chain increments off the last wdata.
    assign time_base = time_w_q.we ? time_w_q.wdata : time_now;

    always_comb begin
        time_w_d.we    = mtime_wr || tick;
        time_w_d.wdata = time_w_q.wdata;
        if (mtime_wr)  time_w_d.wdata = byte_merge(time_now, req_wdata, req_wstrb);
        else if (tick) time_w_d.wdata = time_base + 64'd1;
    end

    always_comb begin
        mip_mtip_d = (time_now >= mtimecmp_q);
        mip_stip_d = stce && (time_now >= csr_clint.stimecmp_rdata.raw);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BUS_IDLE;
            msip_q       <= 1'b0;
            mtimecmp_q   <= '1;
            mip_mtip_q   <= 1'b0;
            mip_stip_q   <= 1'b0;
            time_w_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            msip_q       <= msip_d;
            mtimecmp_q   <= mtimecmp_d;
            mip_mtip_q   <= mip_mtip_d;
            mip_stip_q   <= mip_stip_d;
            time_w_q     <= time_w_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign csr_clint.time_w   = time_w_q;
    assign csr_clint.mip_mtip = mip_mtip_q;
    assign csr_clint.mip_stip = mip_stip_q;
    assign msip               = msip_q;
    assign resp_rdata         = resp_rdata_q;
    assign resp_err           = resp_err_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV=1 and 4) share the bus inputs
// and each loops time_w back into time_rdata through a small CSR model.
module tb_clint_timer;
    import csr_pkg::*;
    import clint_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;

    logic        req_ready1, resp_valid1, resp_err1, msip1;
    logic [63:0] resp_rdata1;
    logic        unused_ready4, unused_rvalid4, unused_rerr4, unused_msip4;
    logic [63:0] unused_rdata4;

    logic [63:0] mcountinhibit = '0;
    logic [63:0] stimecmp      = '0;
    logic [63:0] menvcfg       = '0;

    csr_clint_if if1 ();
    csr_clint_if if4 ();

    // CSR-file model: time register written from time_w, visible next cycle
    logic [63:0] time1_q, time4_q;
    always @(posedge clk) begin
        if (rst)                 time1_q <= '0;
        else if (if1.time_w.we)  time1_q <= if1.time_w.wdata;
        if (rst)                 time4_q <= '0;
        else if (if4.time_w.we)  time4_q <= if4.time_w.wdata;
    end

    assign if1.time_rdata          = time1_q;
    assign if1.mcountinhibit_rdata = mcountinhibit;
    assign if1.stimecmp_rdata      = stimecmp;
    assign if1.menvcfg_rdata       = menvcfg;
    assign if4.time_rdata          = time4_q;
    assign if4.mcountinhibit_rdata = mcountinhibit;
    assign if4.stimecmp_rdata      = stimecmp;
    assign if4.menvcfg_rdata       = menvcfg;

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut1 (
        .clk(clk), .rst(rst), .csr_clint(if1.clint),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .msip(msip1)
    );

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut4 (
        .clk(clk), .rst(rst), .csr_clint(if4.clint),
        .req_valid(req_valid), .req_ready(unused_ready4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(unused_rvalid4), .resp_rdata(unused_rdata4), .resp_err(unused_rerr4),
        .msip(unused_msip4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard
    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        chk_rd;
    } resp_exp_t;
    resp_exp_t exp_q[$];

    always @(negedge clk) begin
        if (resp_valid1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got rdata 0x%h err %0b, expected no response",
                         resp_rdata1, resp_err1);
            end else begin
                resp_exp_t e;
                e = exp_q.pop_front();
                check("resp_err", 64'(resp_err1), 64'(e.err));
                if (e.chk_rd) check("resp_rdata", resp_rdata1, e.rdata);
            end
        end
    end

    // Single access: accept in this cycle, return in the response cycle.
    task automatic bus(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                       input logic [7:0] strb, input logic [63:0] exp_rd,
                       input logic exp_err, input logic chk_rd);
        resp_exp_t e;
        check("req_ready_idle", 64'(req_ready1), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        e.rdata = exp_rd;
        e.err = exp_err;
        e.chk_rd = chk_rd;
        exp_q.push_back(e);
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("resp_valid_pulse", 64'(resp_valid1), 64'd1);
        check("req_ready_in_resp", 64'(req_ready1), 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] rdata;
        logic        err;
        logic        chk_rd;
        logic        msip;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] t0, held;
        int we_cnt;

        vecs.push_back(vec_t'{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 16'h0000, 64'hFFFF_FFFF, 8'h0F, 64'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 16'h4000, 64'hAAAA_BBBB_0000_0000, 8'hF0, 64'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 16'h4000, 64'h0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 16'h1000, 64'h0, 8'h00, 64'h0, 1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 16'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 16'h4008, 64'h0, 8'h00, 64'h0, 1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 16'h0000, 64'h0, 8'hFE, 64'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 16'h0000, 64'h0, 8'h01, 64'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 16'h4000, 64'h0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 1'b1, 1'b0});

        // Reset, then time progression for both prescaler settings
        repeat (3) step();
        check("rst_time_w_we", 64'(if1.time_w.we), 64'd0);
        rst = 1'b0;
        check("rst_req_ready", 64'(req_ready1), 64'd1);
        check("rst_resp_valid", 64'(resp_valid1), 64'd0);
        check("rst_msip", 64'(msip1), 64'd0);
        check("rst_time_w_wdata", if1.time_w.wdata, 64'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("time_div4_k%0d", k), time4_q, (k == 0) ? 64'd0 : 64'((k - 1) / 4));
            check($sformatf("time_div1_k%0d", k), time1_q, (k == 0) ? 64'd0 : 64'(k - 1));
            check("mip_mtip_reset", 64'({if1.mip_mtip, if4.mip_mtip}), 64'd0);
            check("mip_stip_reset", 64'({if1.mip_stip, if4.mip_stip}), 64'd0);
            step();
        end

        // Register access table
        for (int i = 0; i < vecs.size(); i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                vecs[i].rdata, vecs[i].err, vecs[i].chk_rd);
            step();
            check($sformatf("msip_vec%0d", i), 64'(msip1), 64'(vecs[i].msip));
        end

        // mtimecmp=10: mtip rises the cycle after time reaches 10
        bus(1'b1, CLINT_MTIME_OFS, 64'd0, 8'hFF, 64'd0, 1'b0, 1'b0);
        step();
        bus(1'b1, CLINT_MTIMECMP_OFS, 64'd10, 8'hFF, 64'd0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 40 && time1_q != 64'd10; i++) step();
        check("time_reached_10", time1_q, 64'd10);
        check("mtip_before_cmp", 64'(if1.mip_mtip), 64'd0);
        step();
        check("mtip_after_cmp", 64'(if1.mip_mtip), 64'd1);
        t0 = time1_q;
        repeat (5) step();
        check("time_rate_div1", time1_q, t0 + 64'd5);
        bus(1'b1, CLINT_MTIMECMP_OFS, 64'd100, 8'hFF, 64'd0, 1'b0, 1'b0);
        step();
        check("mtip_cleared", 64'(if1.mip_mtip), 64'd0);

        // Timer inhibit holds time; clearing it resumes from the held value
        mcountinhibit = 64'h2;
        we_cnt = 0;
        step();
        held = time1_q;
        for (int i = 0; i < 20; i++) begin
            if (if1.time_w.we) we_cnt++;
            step();
        end
        check("inhibit_no_we", 64'(we_cnt), 64'd0);
        check("inhibit_time_held", time1_q, held);
        bus(1'b0, CLINT_MTIME_OFS, 64'd0, 8'h00, held, 1'b0, 1'b1);
        step();
        mcountinhibit = 64'h0;
        step();
        step();
        check("resume_held_plus1", time1_q, held + 64'd1);
        step();
        check("resume_held_plus2", time1_q, held + 64'd2);

        // Supervisor timer: gated by STCE
        stimecmp = 64'd5;
        step();
        step();
        check("stip_stce0", 64'(if1.mip_stip), 64'd0);
        menvcfg = 64'h8000_0000_0000_0000;
        check("stip_same_cycle", 64'(if1.mip_stip), 64'd0);
        step();
        check("stip_stce1", 64'(if1.mip_stip), 64'd1);
        stimecmp = '1;
        step();
        check("stip_cmp_raised", 64'(if1.mip_stip), 64'd0);
        menvcfg  = '0;
        stimecmp = '0;

        // mtime write beats the same-cycle tick, then time wraps
        bus(1'b1, CLINT_MTIME_OFS, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 1'b0, 1'b0);
        check("mtime_wr_we", 64'(if1.time_w.we), 64'd1);
        check("mtime_wr_wins", if1.time_w.wdata, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("wrap_wdata_ff", if1.time_w.wdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_time_fe", time1_q, 64'hFFFF_FFFF_FFFF_FFFE);
        check("div4_time_written", time4_q, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("wrap_wdata_0", if1.time_w.wdata, 64'd0);
        step();
        check("wrap_time_0", time1_q, 64'd0);
        step();
        check("div4_prescaler_cleared", time4_q, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("div4_first_tick", time4_q, 64'hFFFF_FFFF_FFFF_FFFF);

        // Back-to-back: request held across the response cycle
        check("b2b_ready_first", 64'(req_ready1), 64'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = CLINT_MSIP_OFS;
        exp_q.push_back(resp_exp_t'{64'd0, 1'b0, 1'b1});
        step();
        check("b2b_ready_low", 64'(req_ready1), 64'd0);
        req_addr = CLINT_MTIMECMP_OFS;
        exp_q.push_back(resp_exp_t'{64'd100, 1'b0, 1'b1});
        step();
        check("b2b_ready_back", 64'(req_ready1), 64'd1);
        step();
        req_valid = 1'b0;
        check("b2b_second_resp", 64'(resp_valid1), 64'd1);
        step();
        check("b2b_no_third", 64'(resp_valid1), 64'd0);

        // Reset coinciding with acceptance: the write must not happen
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = CLINT_MSIP_OFS;
        req_wdata = 64'd1;
        req_wstrb = 8'hFF;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        check("rst_accept_msip", 64'(msip1), 64'd0);
        check("rst_accept_no_resp", 64'(resp_valid1), 64'd0);
        step();
        rst = 1'b0;
        step();
        bus(1'b0, CLINT_MTIMECMP_OFS, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        step();
        step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
